code5421_serial_decoder: RTL and testbench
==========================================

Name: code5421_serial_decoder

Overview:
- Receiving end of the 5421-code digit path. Accepts a bit-serial stream of 4-bit 5421-coded decimal digits, MSB first, and reassembles each digit.
- Decodes each digit to 8421 BCD. Optionally undoes a 9's complement applied by the sender.
- Presents each result through a one-entry valid/ready output buffer and groups digits into fixed-length frames.

Parameters:
- DIGITS, 4, number of digits per frame; range 1..8.
- CW, 3, width of the digit index counter; must satisfy 2**CW >= DIGITS.

Ports:
- clock  input  1  rising-edge clock; the only clock in the block.
- reset  input  1  synchronous, active-high reset.
- ser_in  input  1  serial data bit.
- in_valid  input  1  ser_in holds a bit this cycle.
- comp  input  1  digit was sent 9's-complemented; sampled on the cycle bit 3 (first, MSB) is accepted.
- in_ready  output  1  block accepts a bit this cycle.
- bcd  output  4  decoded BCD digit.
- err  output  1  bcd entry came from an illegal 5421 code.
- last  output  1  bcd entry is the final digit of its frame.
- digit_idx  output  CW  position of the bcd entry within its frame, 0-based.
- out_valid  output  1  output buffer holds a digit.
- out_ready  input  1  consumer accepts the buffered digit.

Behaviour:
- Reset (synchronous, active-high): all outputs and internal registers go to zero, the bit state goes to S0, and the frame counter goes to 0.
  - out_valid=0, bcd=0, err=0, last=0, digit_idx=0.
  - in_ready=1 from the first cycle after reset.
  - Reset asserted mid-digit or mid-frame discards the partial bits and any buffered digit. No output is produced for them.
- Bit transfer: occurs when in_valid & in_ready. in_ready = ~(out_valid & ~out_ready), a combinational function of registered state and out_ready.
- Bit FSM, one state per MSB-first bit position:
  - S0 -> S1 -> S2 -> S3, advancing only on a bit transfer; idle cycles hold the state.
  - On a transfer in S0, comp is latched into comp_r.
  - Bits are shifted left into sh[3:0].
  - A transfer in S3 completes the digit and returns to S0.
- Decode, applied on completion to c = {sh[2:0], ser_in}:
  - Legal codes 0000-0100 map to 0-4. Legal codes 1000-1100 map to 5-9 (value = 5*c[3] + c[2:0]).
  - Illegal codes 0101, 0110, 0111, 1101, 1110, 1111 give bcd=0 and err=1.
  - If comp_r=1 and the code is legal, bcd = 9 - value. If comp_r=1 and the code is illegal, still bcd=0, err=1.
- Output buffer:
  - On completion, bcd, err, digit_idx and last load on that clock edge; out_valid=1 from the next cycle. Latency is 1 cycle from the 4th bit edge.
  - out_valid clears when out_ready=1 while out_valid=1, unless a new digit completes in the same cycle. In that case the new digit loads and out_valid stays 1.
  - While out_valid=1 and out_ready=0: the entry is held stable, in_ready=0, and the FSM state and partial shift register are frozen.
- Frame counter:
  - Increments on every completed digit, illegal digits included. Wraps DIGITS-1 -> 0.
  - digit_idx is the counter value before the increment. last=1 when that value = DIGITS-1.
- Not provided: back-to-back bit acceptance across a blocked output slot. A full, non-draining buffer stalls input even for bits 1-3 of the next digit.
- Sustained throughput: one bit per cycle, i.e. one digit per 4 cycles, with out_ready held high.

Test Plan:
- Reset, then send 1010 (comp=0) with in_valid high on 4 consecutive cycles, out_ready=1 -> 1 cycle after the 4th bit edge: out_valid=1, bcd=0111, err=0, digit_idx=0, last=0; out_valid=0 the following cycle.
- Send all 10 legal codes 0000..0100, 1000..1100, comp=0, DIGITS=4 -> bcd 0..9 in order; err=0; last=1 on the 4th and 8th digits; digit_idx sequence 0,1,2,3,0,1,2,3,0,1.
- Send 1010 with comp=1 on bit 3 only (comp toggled low for bits 2-0) -> bcd=0010. Send 0110 with comp=1 -> bcd=0000, err=1, and the frame counter still advances.
- Hold out_ready=0 after a digit completes and keep in_valid=1 -> in_ready=0, and bcd/err/digit_idx/last stay stable for 5 cycles. Raise out_ready -> entry drains, in_ready=1 the same cycle, and the next digit decodes correctly.
- Assert reset for 1 cycle after 2 bits of a digit, then send 0011 -> bcd=0011, digit_idx=0, and no output for the aborted bits.
- Insert idle cycles (in_valid=0) between every bit of 1100 -> bcd=1001 (9), 1 cycle after the final accepted bit.

Source files
------------

// File: rtl/code5421_serial_decoder.sv
// code5421_serial_decoder: receives MSB-first serial 5421-coded digits,
// decodes them to 8421 BCD (optionally undoing a 9's complement) and
// presents each digit through a one-entry valid/ready buffer tagged with
// its position inside a fixed-length frame.
module code5421_serial_decoder #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CW     = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ser_in,
  input  logic          in_valid,
  input  logic          comp,
  output logic          in_ready,
  output logic [3:0]    bcd,
  output logic          err,
  output logic          last,
  output logic [CW-1:0] digit_idx,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);

  state_t        state_q;
  logic [3:0]    sh_q;
  logic          comp_q;
  logic [CW-1:0] cnt_q;

  logic          xfer;
  logic          done;
  logic [3:0]    code;
  logic          legal;
  logic [3:0]    value;
  logic [3:0]    dec_bcd;
  logic          dec_err;

  // A full buffer that is not draining this cycle blocks every incoming bit.
  assign in_ready = ~(out_valid & ~out_ready);
  assign xfer     = in_valid & in_ready;
  assign done     = xfer & (state_q == S3);
  assign code     = {sh_q[2:0], ser_in};

  // 5421 -> 8421 decode of the completing code, with optional 9's complement undo.
  always_comb begin
    legal   = (code[2:0] <= 3'd4);
    value   = code[3] ? (4'(code[2:0]) + 4'd5) : 4'(code[2:0]);
    dec_bcd = 4'd0;
    dec_err = ~legal;
    if (legal) begin
      dec_bcd = comp_q ? (4'd9 - value) : value;
    end
  end

  // Bit FSM, shift register, frame counter and output buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S0;
      sh_q      <= 4'd0;
      comp_q    <= 1'b0;
      cnt_q     <= '0;
      bcd       <= 4'd0;
      err       <= 1'b0;
      last      <= 1'b0;
      digit_idx <= '0;
      out_valid <= 1'b0;
    end else begin
      if (xfer) begin
        sh_q <= code;
        case (state_q)
          S0: begin
            comp_q  <= comp;
            state_q <= S1;
          end
          S1:      state_q <= S2;
          S2:      state_q <= S3;
          default: state_q <= S0;
        endcase
      end

      if (done) begin
        out_valid <= 1'b1;
        bcd       <= dec_bcd;
        err       <= dec_err;
        digit_idx <= cnt_q;
        last      <= (cnt_q == LAST_IDX);
        cnt_q     <= (cnt_q == LAST_IDX) ? '0 : cnt_q + CW'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_code5421_serial_decoder.sv
// Bench for code5421_serial_decoder: directed digits, scoreboard queue of
// expected entries, and an independent monitor that checks each handshake.
module tb_code5421_serial_decoder;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned CW     = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ser_in = 1'b0;
  logic          in_valid = 1'b0;
  logic          comp = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic [3:0]    bcd;
  logic          err;
  logic          last;
  logic [CW-1:0] digit_idx;
  logic          out_valid;

  code5421_serial_decoder #(.DIGITS(DIGITS), .CW(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .ser_in    (ser_in),
    .in_valid  (in_valid),
    .comp      (comp),
    .in_ready  (in_ready),
    .bcd       (bcd),
    .err       (err),
    .last      (last),
    .digit_idx (digit_idx),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]    bcd;
    logic          err;
    logic          last;
    logic [CW-1:0] idx;
  } exp_t;

  exp_t q[$];
  exp_t mx;
  int   total = 0;
  int   bad = 0;
  int   exp_idx = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input int b, input bit e);
    exp_t x;
    x.bcd  = 4'(b);
    x.err  = e;
    x.idx  = CW'(exp_idx);
    x.last = (exp_idx == int'(DIGITS) - 1);
    q.push_back(x);
    exp_idx = (exp_idx + 1) % int'(DIGITS);
  endtask

  // Monitor: every accepted output entry is checked against the queue head.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          mx = q.pop_front();
          chk("bcd", int'(bcd), int'(mx.bcd));
          chk("err", int'(err), int'(mx.err));
          chk("digit_idx", int'(digit_idx), int'(mx.idx));
          chk("last", int'(last), int'(mx.last));
        end
      end
    end
  end

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic c);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    ser_in = b;
    comp = c;
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    if (!acc) chk("bit_accept_timeout", 0, 1);
  endtask

  task automatic send_digit(input logic [3:0] cd, input logic c);
    for (int i = 3; i >= 0; i--) begin
      send_bit(cd[i], (i == 3) ? c : 1'b0);
    end
    in_valid = 1'b0;
    comp = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      sync();
      n++;
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    sync();
    reset = 1'b0;
    exp_idx = 0;
    q.delete();
  endtask

  logic [3:0] codes [10];

  initial begin
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
              4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_bcd", int'(bcd), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_last", int'(last), 0);
    chk("rst_digit_idx", int'(digit_idx), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    sync();

    // Single digit 1010 -> 7, one-cycle latency, valid drops after handshake
    push(7, 1'b0);
    send_digit(4'b1010, 1'b0);
    @(negedge clock);
    chk("latency_valid", int'(out_valid), 1);
    @(negedge clock);
    chk("valid_cleared", int'(out_valid), 0);
    sync();

    // All ten legal codes back to back, frame tagging across two frames
    do_reset();
    for (int i = 0; i < 10; i++) begin
      push(i, 1'b0);
      send_digit(codes[i], 1'b0);
    end
    drain();

    // 9's complement latched on MSB only; illegal code; frame wrap
    push(2, 1'b0);
    send_digit(4'b1010, 1'b1);
    push(0, 1'b1);
    send_digit(4'b0110, 1'b1);
    push(4, 1'b0);
    send_digit(4'b0100, 1'b0);
    drain();

    // Output stall: entry held, input blocked, then release
    out_ready = 1'b0;
    push(3, 1'b0);
    send_digit(4'b0011, 1'b0);
    in_valid = 1'b1;
    ser_in = 1'b1;
    comp = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_bcd", int'(bcd), 3);
      chk("stall_err", int'(err), 0);
      chk("stall_idx", int'(digit_idx), 1);
      chk("stall_last", int'(last), 0);
    end
    sync();
    out_ready = 1'b1;
    push(5, 1'b0);
    @(negedge clock);
    chk("release_in_ready", int'(in_ready), 1);
    sync();
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    in_valid = 1'b0;
    drain();

    // Reset mid-digit discards partial bits and restarts the frame
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    do_reset();
    @(negedge clock);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    sync();
    push(3, 1'b0);
    send_digit(4'b0011, 1'b0);
    drain();

    // Idle cycles between bits of 1100 -> 9
    push(9, 1'b0);
    send_bit(1'b1, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    send_bit(1'b1, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    send_bit(1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    chk("gap_no_early_out", int'(out_valid), 0);
    sync();
    send_bit(1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clock);
    chk("gap_latency_valid", int'(out_valid), 1);
    sync();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
